rs_issue_arbiter: RTL and testbench
===================================

// Module: rs_issue_arbiter
// PURPOSE
//  Scheduler for a bank of NUM_RS reservation stations sharing one execution unit.
//  Dispatch: steers each decoded instruction to the lowest-index free RS (one-hot write enable).
//  Issue: each cycle, grants exactly one ready RS round-robin; stalls every other ready RS.
//  Sits between the decode/ROB stage and the RS bank; its grant mux feeds the execution unit.
// PARAMETERS
//  NUM_RS   4                    number of reservation stations arbitrated (>=2)
//  IDXW     $clog2(NUM_RS)       width of RS index outputs
//  CNTW     16                   width of issued-instruction perf counter
// PORTS
//  clk_i           in   1        clock, all state on rising edge
//  reset_i         in   1        synchronous reset, active-low (0 = reset)
//  flush_i         in   1        pipeline flush (mispredict); sync, active-high
//  decodeValid_i   in   1        decode has an instruction to dispatch this cycle
//  rsBusy_i        in   NUM_RS   busy flag from each RS
//  rsReady_i       in   NUM_RS   ready flag from each RS (both operands resolved)
//  execStall_i     in   1        execution unit cannot accept an instruction this cycle
//  dispatchStall_o out  1        no free RS; decode must hold its instruction
//  rsWriteEn_o     out  NUM_RS   one-hot decodeWriteEn to the chosen free RS
//  rsStall_o       out  NUM_RS   stall to each RS (keeps it busy, blocks issue)
//  grant_o         out  NUM_RS   one-hot issue grant (selects RS output into exec unit)
//  grantIdx_o      out  IDXW     binary index of grant_o
//  issueValid_o    out  1        an instruction is handed to the exec unit this cycle
//  issueCount_o    out  CNTW     count of completed issues since reset/flush
// BEHAVIOUR
//  Reset (reset_i==0 at clk edge): rrPtr=0, state=IDLE, lockIdx=0, issueCount_o=0.
//   Outputs are combinational from state and inputs: during reset, rsWriteEn_o=0, grant_o=0,
//   grantIdx_o=0, issueValid_o=0, rsStall_o=all 1s, dispatchStall_o=1. Reset beats flush.
//  Dispatch (comb): free = ~rsBusy_i. If decodeValid_i && |free: rsWriteEn_o = lowest set bit of free.
//   Else rsWriteEn_o=0. dispatchStall_o = ~|free, independent of decodeValid_i.
//   An RS granted this cycle is still busy: not reusable until the next cycle.
//  Issue FSM (state registered, grant comb):
//   IDLE: cand = rsReady_i & rsBusy_i. Winner = first set bit of cand searching rrPtr, rrPtr+1, ...
//    with wrap mod NUM_RS. If cand==0: grant_o=0, issueValid_o=0.
//    If winner exists and !execStall_i: grant_o=onehot(winner), issueValid_o=1; at the edge
//     rrPtr<=(winner+1)%NUM_RS, issueCount_o++ (wraps at 2^CNTW).
//    If winner exists and execStall_i: grant_o=onehot(winner), issueValid_o=0; at the edge
//     lockIdx<=winner, state<=LOCKED.
//   LOCKED: grant_o=onehot(lockIdx) (held even if another RS became ready).
//    If !execStall_i: issueValid_o=1; at the edge rrPtr<=lockIdx+1, count++, state<=IDLE.
//    Else issueValid_o=0 and the state is unchanged.
//  rsStall_o[i] = ~(issueValid_o && grant_o[i]). Every RS except the one issuing is stalled,
//   so an RS drops busy only in the cycle it actually issues.
//  Flush (flush_i==1 at edge): state<=IDLE, rrPtr<=0, count<=0. While flush_i is high,
//   issueValid_o=0, grant_o=0, rsWriteEn_o=0, rsStall_o=all 1s.
//  Dispatch and issue are independent: they may both act in one cycle on different RSs.
//  Latency: zero-cycle comb grant. One instruction per cycle max throughput.
//  Fairness: a continuously ready RS is granted within NUM_RS issuing cycles.
// TESTING (NUM_RS=4)
//  1 reset_i=0 for 2 cycles with random inputs -> grant_o=0, rsStall_o=4'hF, count=0;
//    after release, rrPtr=0.
//  2 rsBusy_i=4'b0101, decodeValid_i=1 -> rsWriteEn_o=4'b0010; rsBusy_i=4'hF -> rsWriteEn_o=0,
//    dispatchStall_o=1.
//  3 rsBusy=rsReady=4'hF held, execStall=0 for 5 cycles -> grantIdx_o 0,1,2,3,0; issueCount_o=5.
//  4 Ready={0,2}, rrPtr=1, execStall=1 for 3 cycles -> grant=RS2 held, issueValid_o=0.
//    RS1 goes ready during the stall -> still RS2. execStall drops -> RS2 issues, rrPtr=3.
//  5 Same cycle: decode writes free RS3 while RS0 issues -> rsWriteEn_o=4'b1000,
//    grant_o=4'b0001, rsStall_o=4'b1110.
//  6 flush_i=1 while LOCKED -> next cycle IDLE, rrPtr=0, count=0; reset_i=0 mid-LOCKED -> IDLE.

Source files
------------

// File: rtl/rs_issue_arbiter.sv
// rs_issue_arbiter: dispatch steering and round-robin issue arbitration for a
// bank of reservation stations that share one execution unit.
// Dispatch picks the lowest-index free RS. Issue grants one ready RS per cycle,
// searching from the round-robin pointer. A grant blocked by an execution stall
// is locked until it issues.
module rs_issue_arbiter #(
  parameter int NUM_RS = 4,
  parameter int IDXW   = $clog2(NUM_RS),
  parameter int CNTW   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              decodeValid_i,
  input  logic [NUM_RS-1:0] rsBusy_i,
  input  logic [NUM_RS-1:0] rsReady_i,
  input  logic              execStall_i,
  output logic              dispatchStall_o,
  output logic [NUM_RS-1:0] rsWriteEn_o,
  output logic [NUM_RS-1:0] rsStall_o,
  output logic [NUM_RS-1:0] grant_o,
  output logic [IDXW-1:0]   grantIdx_o,
  output logic              issueValid_o,
  output logic [CNTW-1:0]   issueCount_o
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_r;
  logic [IDXW-1:0]   rr_ptr_r;
  logic [IDXW-1:0]   lock_idx_r;
  logic [CNTW-1:0]   issue_count_r;

  logic [NUM_RS-1:0] free_s;
  logic [NUM_RS-1:0] low_free_s;
  logic [NUM_RS-1:0] cand_s;
  logic [IDXW-1:0]   probe_s;
  logic              win_found_s;
  logic [IDXW-1:0]   win_idx_s;
  logic              sel_valid_s;
  logic [IDXW-1:0]   sel_idx_s;
  logic [NUM_RS-1:0] grant_s;
  logic              issue_valid_s;
  logic [NUM_RS-1:0] write_en_s;
  logic              dispatch_stall_s;

  // Index successor with wrap at NUM_RS (works for non-power-of-two banks).
  function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
    logic [IDXW-1:0] nxt;
    if (idx == IDXW'(NUM_RS - 1)) begin
      nxt = {IDXW{1'b0}};
    end else begin
      nxt = idx + {{(IDXW-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

  // Free map and its lowest set bit (x & -x isolates the lowest one).
  assign free_s     = ~rsBusy_i;
  assign low_free_s = free_s & (~free_s + {{(NUM_RS-1){1'b0}}, 1'b1});
  assign cand_s     = rsReady_i & rsBusy_i;

  // Round-robin search: first candidate at or after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDXW{1'b0}};
    probe_s     = rr_ptr_r;
    for (int k = 0; k < NUM_RS; k++) begin
      if (!win_found_s && cand_s[probe_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = probe_s;
      end else begin
        win_found_s = win_found_s;
      end
      probe_s = next_idx(probe_s);
    end
  end

  // Issue selection: locked RS wins over any new search; reset/flush silence it.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = {IDXW{1'b0}};
    if (!reset_i || flush_i) begin
      sel_valid_s = 1'b0;
      sel_idx_s   = {IDXW{1'b0}};
    end else if (state_r == LOCKED) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = lock_idx_r;
    end else if (win_found_s) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = win_idx_s;
    end else begin
      sel_valid_s = 1'b0;
      sel_idx_s   = {IDXW{1'b0}};
    end
  end

  assign grant_s       = sel_valid_s ? ({{(NUM_RS-1){1'b0}}, 1'b1} << sel_idx_s)
                                     : {NUM_RS{1'b0}};
  assign issue_valid_s = sel_valid_s && !execStall_i;

  // Dispatch steering: only the lowest free RS is written; stall tracks free space.
  always_comb begin
    write_en_s       = {NUM_RS{1'b0}};
    dispatch_stall_s = ~|free_s;
    if (!reset_i) begin
      write_en_s       = {NUM_RS{1'b0}};
      dispatch_stall_s = 1'b1;
    end else if (flush_i) begin
      write_en_s       = {NUM_RS{1'b0}};
      dispatch_stall_s = ~|free_s;
    end else if (decodeValid_i) begin
      write_en_s       = low_free_s;
      dispatch_stall_s = ~|free_s;
    end else begin
      write_en_s       = {NUM_RS{1'b0}};
      dispatch_stall_s = ~|free_s;
    end
  end

  // Issue FSM, round-robin pointer and issued-instruction counter.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r       <= IDLE;
      rr_ptr_r      <= {IDXW{1'b0}};
      lock_idx_r    <= {IDXW{1'b0}};
      issue_count_r <= {CNTW{1'b0}};
    end else if (flush_i) begin
      state_r       <= IDLE;
      rr_ptr_r      <= {IDXW{1'b0}};
      issue_count_r <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s && !execStall_i) begin
            rr_ptr_r      <= next_idx(win_idx_s);
            issue_count_r <= issue_count_r + {{(CNTW-1){1'b0}}, 1'b1};
          end else if (win_found_s) begin
            lock_idx_r <= win_idx_s;
            state_r    <= LOCKED;
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (!execStall_i) begin
            rr_ptr_r      <= next_idx(lock_idx_r);
            issue_count_r <= issue_count_r + {{(CNTW-1){1'b0}}, 1'b1};
            state_r       <= IDLE;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dispatchStall_o = dispatch_stall_s;
  assign rsWriteEn_o     = write_en_s;
  assign grant_o         = grant_s;
  assign grantIdx_o      = sel_idx_s;
  assign issueValid_o    = issue_valid_s;
  assign rsStall_o       = ~(grant_s & {NUM_RS{issue_valid_s}});
  assign issueCount_o    = issue_count_r;

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Scoreboard bench for rs_issue_arbiter (NUM_RS=4): a driver applies stimulus on
// the falling edge and pushes the reference model's expected outputs; a monitor
// pops and compares them a few ns later, before the next rising edge.
module tb_rs_issue_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        decode_valid = 1'b0;
  logic [3:0]  rs_busy = 4'h0;
  logic [3:0]  rs_ready = 4'h0;
  logic        exec_stall = 1'b0;
  logic        dispatch_stall;
  logic [3:0]  rs_write_en;
  logic [3:0]  rs_stall;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        issue_valid;
  logic [15:0] issue_count;

  always #5 clk = ~clk;

  rs_issue_arbiter #(.NUM_RS(4), .IDXW(2), .CNTW(16)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .decodeValid_i(decode_valid),
    .rsBusy_i(rs_busy), .rsReady_i(rs_ready), .execStall_i(exec_stall),
    .dispatchStall_o(dispatch_stall), .rsWriteEn_o(rs_write_en), .rsStall_o(rs_stall),
    .grant_o(grant), .grantIdx_o(grant_idx), .issueValid_o(issue_valid),
    .issueCount_o(issue_count)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  we;
    logic        dstall;
    logic [3:0]  grant;
    logic [1:0]  gidx;
    logic        iv;
    logic [3:0]  rstall;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  // Reference model state, kept as plain integers.
  int m_rr = 0;
  int m_locked = 0;
  int m_lock = 0;
  int m_cnt = 0;

  task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic dv,
                      input logic [3:0] b, input logic [3:0] rd, input logic es);
    exp_t e;
    int   win;
    int   sel;
    bit   found;
    bit   sel_ok;
    @(negedge clk);
    reset = r; flush = f; decode_valid = dv;
    rs_busy = b; rs_ready = rd; exec_stall = es;
    cyc_no++;
    e.cyc = cyc_no;
    e.cnt = 16'(m_cnt);
    // candidate search from the round-robin pointer
    found = 1'b0; win = 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (!found && b[i] && rd[i]) begin found = 1'b1; win = i; end
    end
    sel_ok = 1'b0; sel = 0;
    if (r && !f) begin
      if (m_locked != 0) begin sel_ok = 1'b1; sel = m_lock; end
      else if (found) begin sel_ok = 1'b1; sel = win; end
    end
    e.grant = sel_ok ? 4'(1 << sel) : 4'h0;
    e.gidx  = 2'(sel);
    e.iv    = sel_ok && !es;
    e.rstall = e.iv ? ~e.grant : 4'hF;
    // dispatch: lowest free RS
    e.we = 4'h0;
    e.dstall = (b == 4'hF);
    if (!r) e.dstall = 1'b1;
    if (r && !f && dv) begin
      for (int i = N - 1; i >= 0; i--) if (!b[i]) e.we = 4'(1 << i);
    end
    q.push_back(e);
    // state update at the coming edge
    if (!r) begin
      m_rr = 0; m_locked = 0; m_lock = 0; m_cnt = 0;
    end else if (f) begin
      m_rr = 0; m_locked = 0; m_cnt = 0;
    end else if (m_locked != 0) begin
      if (!es) begin m_rr = (m_lock + 1) % N; m_cnt = (m_cnt + 1) % 65536; m_locked = 0; end
    end else if (found) begin
      if (!es) begin m_rr = (win + 1) % N; m_cnt = (m_cnt + 1) % 65536; end
      else begin m_lock = win; m_locked = 1; end
    end
  endtask

  // Monitor: compare DUT outputs with the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("write_en",       e.cyc, 16'(rs_write_en),    16'(e.we));
        chk("dispatch_stall", e.cyc, 16'(dispatch_stall), 16'(e.dstall));
        chk("grant",          e.cyc, 16'(grant),          16'(e.grant));
        chk("grant_idx",      e.cyc, 16'(grant_idx),      16'(e.gidx));
        chk("issue_valid",    e.cyc, 16'(issue_valid),    16'(e.iv));
        chk("rs_stall",       e.cyc, 16'(rs_stall),       16'(e.rstall));
        chk("issue_count",    e.cyc, issue_count,         e.cnt);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    // reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    // dispatch steering and full bank
    step(1'b1, 1'b0, 1'b1, 4'b0101, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 1'b0);
    // all ready, round-robin 0,1,2,3,0
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    // pointer now 1: RS2 wins and is held through the stall
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'b0101, 4'b0101, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'b0111, 4'b0111, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'b0111, 4'b0111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    // simultaneous dispatch to RS3 and issue from RS0
    step(1'b1, 1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
    // flush while locked, then reset while locked
    step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 19) == 0),
           1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    repeat (2) @(negedge clk);
    #5;
    chk("queue_drained", cyc_no, 16'(q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
